// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative ALU/MDU.
// Operation codes, FSM states, flag bit positions and the illegal-op fill pattern.
package alu_pkg;

   localparam int unsigned MAX_WIDTH = 1024;
   localparam int unsigned MAX_IDXW  = $clog2(MAX_WIDTH);

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLT   = 4'd5,
      OP_SLTU  = 4'd6,
      OP_MUL   = 4'd8,
      OP_MULHU = 4'd9,
      OP_DIVU  = 4'd10,
      OP_REMU  = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } alu_state_e;

   // Repeating 0xDEADBEEF, low 'width' bits populated, the rest zero.
   function automatic logic [MAX_WIDTH-1:0] illegal_pattern(input int unsigned width);
      logic [31:0]          pat;
      logic [MAX_WIDTH-1:0] p;
      pat = 32'hDEADBEEF;
      p   = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) p[i[MAX_IDXW-1:0]] = pat[i[4:0]];
      end
      return p;
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// 2*WIDTH accumulator; one step per i_step cycle, WIDTH steps per operation.
module iter_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_step,
   input  logic             i_div,
   input  logic             i_hi,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_m;
   logic               r_div;
   logic               r_hi;
   logic [CW-1:0]      r_cnt;

   logic [WIDTH:0]     w_add;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_rem_sh;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_next;

   // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
   assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : '0)};
   assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; a zero divisor naturally
   // yields an all-ones quotient and the dividend as remainder.
   assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge       = (w_rem_sh >= {1'b0, r_m});
   assign w_diff     = r_acc[2*WIDTH-2:WIDTH-1] - r_m;
   assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                            : {r_acc[2*WIDTH-2:0], 1'b0};

   assign w_next   = r_div ? w_div_next : w_mul_next;
   assign o_result = r_hi ? w_next[2*WIDTH-1:WIDTH] : w_next[WIDTH-1:0];
   assign o_done   = i_step & (r_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_m   <= '0;
         r_div <= 1'b0;
         r_hi  <= 1'b0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_acc <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
         r_m   <= i_div ? i_b : i_a;
         r_div <= i_div;
         r_hi  <= i_hi;
         r_cnt <= '0;
      end else if (i_step) begin
         r_acc <= w_next;
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU/MDU top: handshake FSM, single-cycle datapath, flags and
// registered outputs; MUL/DIV family delegated to iter_muldiv.
module alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam logic [MAX_WIDTH-1:0] ILL_FULL = illegal_pattern(WIDTH);
   localparam logic [WIDTH-1:0]     ILL_PAT  = ILL_FULL[WIDTH-1:0];

   alu_state_e       r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;

   logic             w_hs;
   logic             w_is_iter;
   logic             w_sub;
   logic [WIDTH-1:0] w_bx;
   logic [WIDTH:0]   w_sum;
   logic             w_v;
   logic             w_legal;
   logic [WIDTH-1:0] w_sc_res;
   logic [3:0]       w_sc_flags;
   logic             w_md_start;
   logic             w_md_step;
   logic             w_md_done;
   logic [WIDTH-1:0] w_md_res;
   logic [3:0]       w_md_flags;

   assign in_ready   = (r_state == IDLE) | ((r_state == DONE) & out_ready);
   assign w_hs       = in_valid & in_ready;
   assign w_is_iter  = (op == OP_MUL) | (op == OP_MULHU) | (op == OP_DIVU) | (op == OP_REMU);
   assign w_md_start = w_hs & w_is_iter;
   assign w_md_step  = (r_state == BUSY);

   // SUB and both compares share the adder as a + ~b + 1.
   assign w_sub = (op == OP_SUB) | (op == OP_SLT) | (op == OP_SLTU);
   assign w_bx  = b ^ {WIDTH{w_sub}};
   assign w_sum = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
   assign w_v   = (a[WIDTH-1] == w_bx[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      w_sc_res   = ILL_PAT;
      w_sc_flags = '0;
      w_legal    = 1'b1;
      case (op)
         OP_ADD, OP_SUB: begin
            w_sc_res           = w_sum[WIDTH-1:0];
            w_sc_flags[FLAG_C] = w_sum[WIDTH];
            w_sc_flags[FLAG_V] = w_v;
         end
         OP_AND:  w_sc_res = a & b;
         OP_OR:   w_sc_res = a | b;
         OP_XOR:  w_sc_res = a ^ b;
         OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_v};
         OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, ~w_sum[WIDTH]};
         default: w_legal = 1'b0;
      endcase
      if (w_legal) begin
         w_sc_flags[FLAG_N] = w_sc_res[WIDTH-1];
         w_sc_flags[FLAG_Z] = (w_sc_res == '0);
      end
   end

   always_comb begin
      w_md_flags         = '0;
      w_md_flags[FLAG_N] = w_md_res[WIDTH-1];
      w_md_flags[FLAG_Z] = (w_md_res == '0);
   end

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_md_start),
      .i_step   (w_md_step),
      .i_div    (op[1]),
      .i_hi     (op[0]),
      .i_a      (a),
      .i_b      (b),
      .o_done   (w_md_done),
      .o_result (w_md_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
      end else begin
         case (r_state)
            BUSY: begin
               if (w_md_done) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_md_res;
                  r_flags     <= w_md_flags;
               end
            end
            // IDLE and DONE share the accept path; in DONE a handshake also retires the old result.
            default: begin
               if (w_hs) begin
                  if (w_is_iter) begin
                     r_state     <= BUSY;
                     r_out_valid <= 1'b0;
                  end else begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_sc_res;
                     r_flags     <= w_sc_flags;
                  end
               end else if ((r_state == DONE) && out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign flags     = r_flags;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: vector table plus scoreboard queue,
// hand sequences for latency, back-pressure, back-to-back and reset cases.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] a, b, result;
   logic [3:0]  flags;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, result16;
   logic [3:0]  flags16;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      logic [3:0]  op;
   } exp_t;
   exp_t sbq[$];
   int   pop_cyc[$];

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;
   vec_t vecs[18];

   alu_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   alu_iter #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
      .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .flags(flags16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model, flags packed as {V,C,N,Z} above the 32-bit result.
   function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      logic [63:0] p;
      logic        v, c, legal;
      r = '0; v = 1'b0; c = 1'b0; legal = 1'b1;
      p = 64'(x) * 64'(y);
      case (o)
         4'd0: begin
            {c, r} = {1'b0, x} + {1'b0, y};
            v = (~x[31] & ~y[31] & r[31]) | (x[31] & y[31] & ~r[31]);
         end
         4'd1: begin
            r = x - y;
            c = (x >= y);
            v = (~x[31] & y[31] & r[31]) | (x[31] & ~y[31] & ~r[31]);
         end
         4'd2:  r = x & y;
         4'd3:  r = x | y;
         4'd4:  r = x ^ y;
         4'd5:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6:  r = (x < y) ? 32'd1 : 32'd0;
         4'd8:  r = p[31:0];
         4'd9:  r = p[63:32];
         4'd10: r = (y == 0) ? 32'hFFFFFFFF : x / y;
         4'd11: r = (y == 0) ? x : x % y;
         default: begin r = 32'hDEADBEEF; legal = 1'b0; end
      endcase
      return {v, c, legal & r[31], legal & (r == 0), r};
   endfunction

   // Scoreboard consumer: compare each retired result against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         pop_cyc.push_back(cyc);
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h expected none", result);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("result op=%0d", e.op), 64'(result), 64'(e.res));
            chk($sformatf("flags op=%0d", e.op), 64'(flags), 64'(e.flg));
         end
      end
   end

   task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [3:0] ef);
      bit done;
      done = 0;
      op = o; a = x; b = y; in_valid = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sbq.push_back('{res: er, flg: ef, op: o});
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      logic [35:0] m;
      logic [3:0]  ro;
      logic [31:0] rx, ry;
      int          n, n0;
      bit          seen;

      vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010};
      vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0101};
      vecs[2]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
      vecs[3]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001};
      vecs[4]  = '{4'd7,  32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 4'b0000};
      vecs[5]  = '{4'd8,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b0010};
      vecs[6]  = '{4'd9,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0000};
      vecs[7]  = '{4'd10, 32'd100,      32'd7,        32'd14,       4'b0000};
      vecs[8]  = '{4'd11, 32'd100,      32'd7,        32'd2,        4'b0000};
      vecs[9]  = '{4'd10, 32'd1234,     32'd0,        32'hFFFFFFFF, 4'b0010};
      vecs[10] = '{4'd11, 32'd9,        32'd0,        32'd9,        4'b0000};
      vecs[11] = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010};
      vecs[12] = '{4'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
      vecs[13] = '{4'd4,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0001};
      vecs[14] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101};
      vecs[15] = '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010};
      vecs[16] = '{4'd15, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 4'b0000};
      vecs[17] = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset flags", 64'(flags), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);

      @(posedge clk); #1;
      out_ready = 1'b1;
      foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
      repeat (3) @(posedge clk);
      #1;

      // MUL latency: handshake edge to out_valid.
      out_ready = 1'b0;
      send(4'd8, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 4'b0010);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mul latency", 64'(n + 1), 64'd33);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Back-pressure on a DIVU result.
      out_ready = 1'b0;
      send(4'd10, 32'd100, 32'd7, 32'd14, 4'b0000);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold result", 64'(result), 64'd14);
         chk("hold in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back ADDs: one retirement per cycle, in order.
      n0 = pop_cyc.size();
      for (int k = 0; k < 4; k++) send(4'd0, 32'(k * 3), 32'(k + 10), 32'(k * 4 + 10), 4'b0000);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b count", 64'(pop_cyc.size() - n0), 64'd4);
      for (int k = 0; k < 3; k++)
         if (pop_cyc.size() > n0 + k + 1)
            chk("b2b spacing", 64'(pop_cyc[n0 + k + 1] - pop_cyc[n0 + k]), 64'd1);

      // Random ops against the reference model.
      for (int k = 0; k < 24; k++) begin
         ro = 4'($urandom_range(0, 15));
         rx = (k % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         ry = (k % 5 == 0) ? 32'd0 : ((k % 3 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
         m  = model(ro, rx, ry);
         send(ro, rx, ry, m[31:0], m[35:32]);
      end
      repeat (3) @(posedge clk);
      #1;

      // WIDTH=16 instance: illegal pattern truncation and overflow flags.
      out_ready16 = 1'b1;
      op16 = 4'd7; a16 = 16'h1234; b16 = 16'h5678; in_valid16 = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready16 && n < 50);
      @(posedge clk); #1;
      op16 = 4'd0; a16 = 16'h7FFF; b16 = 16'h0001;
      @(negedge clk);
      chk("w16 illegal result", 64'(result16), 64'h0000BEEF);
      chk("w16 illegal flags", 64'(flags16), 64'd0);
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      @(negedge clk);
      chk("w16 add result", 64'(result16), 64'h8000);
      chk("w16 add flags", 64'(flags16), 64'b1010);

      // Reset during BUSY discards the in-flight MUL.
      while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
      send(4'd8, 32'd7, 32'd9, 32'd63, 4'b0000);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst async out_valid", 64'(out_valid), 64'd0);
      chk("rst async result", 64'(result), 64'd0);
      sbq.delete();
      @(posedge clk); #1 rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("rst discards op", 64'(seen), 64'd0);

      send(4'd1, 32'd10, 32'd3, 32'd7, 4'b0100);
      n = 0;
      while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("scoreboard drained", 64'(sbq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised iterative ALU/MDU for the RISC-V core. It extends the single-cycle ALU with a WIDTH parameter, XOR/SLTU operations, and unsigned multiply and divide/remainder. Every result is registered behind a valid/ready handshake, so the block can sit in a multi-cycle or stalled pipeline execute stage. Single-cycle ops complete in 1 cycle; MUL/DIV ops iterate for WIDTH cycles.

## Interface
- WIDTH, 32, datapath width; multiple of 8, ≥ 8.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  operation code, alu_op_e.
- a, b  in  WIDTH each  operands, sampled on input handshake.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- flags  out  4  {V, C, N, Z}.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU: single-cycle.
  - 8 MUL (low WIDTH bits of a*b), 9 MULHU (high WIDTH bits, unsigned), 10 DIVU, 11 REMU: iterative.
  - 7, 12–15: illegal.
- SUB is computed as a + ~b + 1. SLT/SLTU return 1 or 0, zero-extended to WIDTH.
- SLT is true when N ^ V of the subtraction is 1.
- Division by zero: DIVU returns all ones; REMU returns a. The iteration count is unchanged.
- Illegal op: completes as single-cycle. result = low WIDTH bits of the repeating pattern 0xDEADBEEF; flags = 0.
- Flags:
  - Z = (result == 0); N = result[WIDTH-1].
  - C = carry out of the adder for ADD/SUB (for SUB, 1 = no borrow); else 0.
  - V = signed overflow for ADD/SUB; else 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, handshake, single-cycle op → DONE.
  - IDLE, handshake, iterative op → BUSY; count = 0.
  - BUSY: one shift-add or restore step per cycle. When count reaches WIDTH-1 → DONE.
  - DONE: out_valid = 1. If out_ready and in_valid → same transitions as from IDLE (back-to-back). If out_ready only → IDLE.
- in_ready = (state == IDLE) | (state == DONE & out_ready). Combinational; depends on out_ready.
- result and flags are held stable while out_valid = 1 and out_ready = 0.
- Operands are latched on the input handshake; a and b are don't-care afterwards.
- in_valid while BUSY is ignored (in_ready = 0). The requester must hold it.

## Timing
- Reset values: state = IDLE, out_valid = 0, result = 0, flags = 0, count = 0. in_ready = 1 after reset.
- Single-cycle op: handshake in cycle T → out_valid = 1 in cycle T+1.
- Iterative op: handshake in cycle T → out_valid = 1 in cycle T+WIDTH+1.
- Peak throughput: one single-cycle op per clock while out_ready is held at 1.
- rst asserted mid-BUSY or in DONE: in-flight op and pending result are discarded immediately; outputs take reset values asynchronously.
- Output handshake and new input handshake in the same DONE cycle: the old result retires, and the new op starts from the same edge.

## Structure
- Package alu_pkg holds:
  - alu_op_e (4-bit enum);
  - alu_state_e {IDLE, BUSY, DONE};
  - flag index localparams FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2, FLAG_V = 3;
  - function illegal_pattern(WIDTH).
- Sub-module iter_muldiv(WIDTH): a shift-add multiplier and a restoring divider. They share a 2*WIDTH accumulator and a $clog2(WIDTH)-bit counter. It provides start/done signals and a product-high/low or quotient/remainder select.
- alu_iter owns the FSM, the single-cycle datapath, the flag logic and the output registers.

## Test plan
- Reset: rst = 1, then release → out_valid = 0, result = 0, flags = 0, in_ready = 1.
- ADD and SUB, WIDTH = 32:
  - ADD 0x7FFFFFFF + 1 → 0x80000000, flags V = 1, C = 0, N = 1, Z = 0, 1 cycle later.
  - SUB 5 − 5 → 0, Z = 1, C = 1.
- Compares and illegal op: SLT 0xFFFFFFFF, 1 → 1; SLTU on the same operands → 0. op = 7 → result 0xDEADBEEF, flags 0. With WIDTH = 16, op = 7 → 0xBEEF.
- MUL family:
  - MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE.
  - MULHU on the same operands → 0x00000001.
  - out_valid exactly 33 cycles after the input handshake.
- DIV family:
  - DIVU 100 / 7 → 14; REMU → 2.
  - DIVU x / 0 → 0xFFFFFFFF; REMU 9 % 0 → 9.
  - out_ready held at 0 for 5 cycles: result stable, in_ready = 0.
- Concurrency:
  - rst pulsed at BUSY cycle 10 → out_valid never rises for that op.
  - Back-to-back ADDs with out_ready = 1 → one result per cycle, in order.
